// File: rtl/pio_in_edge_capture.sv
// ---------------------------------------------------------------------------
// pio_in_edge_capture
//   Avalon-MM input PIO with a synchronizer on every input bit. Each bit has a
//   sticky edge-capture flag and an interrupt mask, and the block drives one
//   IRQ line. It uses word addresses 0..3 and returns read data one cycle
//   after the read.
//
// Parameters
//   WIDTH        number of input bits (1..32)
//   SYNC_STAGES  synchronizer depth on in_port (2..4)
//   EDGE_TYPE    0 = rising, 1 = falling, 2 = any edge sets a capture bit
//   IRQ_MODE     0 = level (synced data & mask), 1 = edge (capture & mask)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     Avalon word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data
//   irq         interrupt request, active-high
//
// Bus handshake: there is no waitrequest.
//   - A write is accepted on every clock edge where chipselect is 1 and
//     write_n is 0.
//   - A read is any cycle where chipselect is 1. Its data appears on readdata
//     after that edge.
//   - readdata is 0 whenever chipselect was 0 at the sampling edge.
//
// Register map
//   0  R: synchronized input data          W: ignored
//   1  R: zero (input-only, no direction)  W: ignored
//   2  R/W: interrupt mask
//   3  R: capture flags                    W: write 1 to clear a bit
// ---------------------------------------------------------------------------
module pio_in_edge_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] capture_q;
  logic [CW-1:0]    arm_cnt;
  logic             arm_done;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clear_vec;
  logic [WIDTH-1:0] read_mux;
  logic             wr_en;

  assign data_q = sync_q[SYNC_STAGES-1];
  assign wr_en  = chipselect & ~write_n;

  // Synchronizer chain plus a one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= data_q;
    end
  end

  // After reset the chain fills from zero. A high input would look like a
  // rising edge while it fills. Edge detection stays disabled until the chain
  // and prev_q hold real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (arm_cnt != CW'(ARM_MAX)) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign arm_done = (arm_cnt == CW'(ARM_MAX));

  always_comb begin
    edge_raw = data_q & ~prev_q;
    if (EDGE_TYPE == 1) begin
      edge_raw = ~data_q & prev_q;
    end else if (EDGE_TYPE == 2) begin
      edge_raw = data_q ^ prev_q;
    end
  end

  assign edge_vec  = edge_raw & {WIDTH{arm_done}};
  assign clear_vec = (wr_en && address == 2'd3) ? writedata : '0;

  // A new edge is ORed in after the clear, so it wins over a clear of the
  // same bit in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_q <= '0;
    end else begin
      capture_q <= (capture_q & ~clear_vec) | edge_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else if (wr_en && address == 2'd2) begin
      mask_q <= writedata;
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux = data_q;
      2'd2:    read_mux = mask_q;
      2'd3:    read_mux = capture_q;
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= chipselect ? read_mux : '0;
    end
  end

  assign irq = (IRQ_MODE == 0) ? |(data_q & mask_q) : |(capture_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// ---------------------------------------------------------------------------
// tb_pio_in_edge_capture
//   Drives three configurations from one shared bus and input:
//     u_rise  rising edge, edge IRQ
//     u_any   any edge, edge IRQ
//     u_lvl   rising edge, level IRQ
//   A reference model keeps the sampled input history. It derives the
//   synchronized data by looking back SYNC_STAGES samples. Edges are armed
//   once SYNC_STAGES+2 edges have passed since reset release.
// ---------------------------------------------------------------------------
module tb_pio_in_edge_capture;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [W-1:0] writedata;
  logic [W-1:0] in_port;
  logic [W-1:0] rd_rise, rd_any, rd_lvl;
  logic         irq_rise, irq_any, irq_lvl;

  always #5 clk = ~clk;

  pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_MODE(1)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise));

  pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .IRQ_MODE(1)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any));

  pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_MODE(0)) u_lvl (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_lvl), .irq(irq_lvl));

  // ---------------- scoreboard / reference model ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] hist_q[$];   // in_port sampled at each edge since reset release
  logic [W-1:0] exp_q[$];    // expected values for directed checks
  logic [W-1:0] m_cap [3];
  logic [W-1:0] m_rd  [3];
  logic [W-1:0] m_mask;

  function automatic logic [W-1:0] dq_at(int k);
    // synchronized data after k edges since release
    if (k >= S) return hist_q[k-S];
    return '0;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    m_mask = '0;
    for (int v = 0; v < 3; v++) begin
      m_cap[v] = '0;
      m_rd[v]  = '0;
    end
  endtask

  task automatic model_edge();
    int           n;
    logic [W-1:0] cur, prv, clr, rd;
    logic [W-1:0] ev [3];
    if (reset) begin
      model_reset();
      return;
    end
    n   = hist_q.size() + 1;
    cur = dq_at(n - 1);
    prv = dq_at(n - 2);
    ev[0] = cur & ~prv;
    ev[1] = cur ^ prv;
    ev[2] = cur & ~prv;
    clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
    for (int v = 0; v < 3; v++) begin
      case (address)
        2'd0:    rd = cur;
        2'd2:    rd = m_mask;
        2'd3:    rd = m_cap[v];
        default: rd = '0;
      endcase
      m_rd[v] = chipselect ? rd : '0;
      if (n < S + 2) ev[v] = '0;
      m_cap[v] = (m_cap[v] & ~clr) | ev[v];
    end
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata;
    hist_q.push_back(in_port);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_exp(input string tag, input logic [W-1:0] obs);
    check(tag, obs, exp_q.pop_front());
  endtask

  task automatic check_all();
    check("rd_rise", rd_rise, m_rd[0]);
    check("rd_any",  rd_any,  m_rd[1]);
    check("rd_lvl",  rd_lvl,  m_rd[2]);
    check("irq_rise", W'(irq_rise), W'(|(m_cap[0] & m_mask)));
    check("irq_any",  W'(irq_any),  W'(|(m_cap[1] & m_mask)));
    check("irq_lvl",  W'(irq_lvl),  W'(|(dq_at(hist_q.size()) & m_mask)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    bus_idle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset   = 1'b1;
    in_port = 8'hFF;
    bus_idle();
    model_reset();
    ticks(2);
    exp_q.push_back(8'h00); check_exp("reset_rd", rd_rise);
    exp_q.push_back(8'h00); check_exp("reset_irq", W'(irq_rise));

    // 1: release with inputs already high; no false capture
    reset      = 1'b0;
    chipselect = 1'b1;
    address    = 2'd0;
    ticks(4);
    exp_q.push_back(8'hFF); check_exp("t1_data", rd_rise);
    bus_read(2'd3);
    exp_q.push_back(8'h00); check_exp("t1_cap_rise", rd_rise);
    exp_q.push_back(8'h00); check_exp("t1_cap_any", rd_any);
    exp_q.push_back(8'h00); check_exp("t1_irq", W'(irq_rise));

    // 2: rising edge on bit 0 with mask 01
    in_port = 8'h00;
    ticks(4);
    bus_write(2'd3, 8'hFF);
    bus_write(2'd2, 8'h01);
    in_port = 8'h01;
    ticks(S);
    exp_q.push_back(8'h00); check_exp("t2_irq_early", W'(irq_rise));
    tick();
    exp_q.push_back(8'h01); check_exp("t2_irq", W'(irq_rise));
    bus_read(2'd3);
    exp_q.push_back(8'h01); check_exp("t2_cap", rd_rise);

    // 3: write-1-to-clear, then a zero write leaves capture alone
    bus_write(2'd3, 8'h01);
    exp_q.push_back(8'h00); check_exp("t3_irq_clr", W'(irq_rise));
    in_port = 8'h03;
    ticks(S + 1);
    bus_write(2'd3, 8'h00);
    bus_read(2'd3);
    exp_q.push_back(8'h02); check_exp("t3_cap_kept", rd_rise);
    bus_write(2'd3, 8'h02);

    // 4: clear of bit 3 in the cycle its edge is detected
    in_port = 8'h0B;
    ticks(S);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 8'h08;
    tick();
    bus_idle();
    bus_read(2'd3);
    exp_q.push_back(8'h08); check_exp("t4_set_wins", rd_rise);

    // 5: falling edge on bit 7 in any-edge mode, masked then unmasked
    bus_write(2'd2, 8'h00);
    in_port = 8'h8B;
    ticks(S + 2);
    bus_write(2'd3, 8'hFF);
    in_port = 8'h0B;
    ticks(S + 1);
    bus_read(2'd3);
    exp_q.push_back(8'h80); check_exp("t5_cap_any", rd_any);
    exp_q.push_back(8'h00); check_exp("t5_irq_masked", W'(irq_any));
    bus_write(2'd2, 8'h80);
    exp_q.push_back(8'h01); check_exp("t5_irq_unmasked", W'(irq_any));

    // 6: level IRQ follows data, reset mid-operation clears everything
    in_port = 8'h00;
    ticks(3);
    bus_write(2'd2, 8'h02);
    in_port = 8'h02;
    ticks(S - 1);
    exp_q.push_back(8'h00); check_exp("t6_lvl_early", W'(irq_lvl));
    tick();
    exp_q.push_back(8'h01); check_exp("t6_lvl_hi", W'(irq_lvl));
    in_port = 8'h00;
    ticks(S);
    exp_q.push_back(8'h00); check_exp("t6_lvl_lo", W'(irq_lvl));
    in_port = 8'h02;
    ticks(S);
    chipselect = 1'b1;
    address    = 2'd2;
    tick();
    exp_q.push_back(8'h02); check_exp("t6_mask_rd", rd_lvl);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    exp_q.push_back(8'h00); check_exp("t6_rst_irq", W'(irq_lvl));
    exp_q.push_back(8'h00); check_exp("t6_rst_rd", rd_lvl);
    @(negedge clk);
    tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(8'h00); check_exp("t6_mask_cleared", rd_lvl);
    bus_idle();

    // random phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    bus_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
